threat_scanner: RTL and testbench

Parametrised, sequential successor to the gobang threat finder. It scans a latched board one cell per clock and classifies every empty cell by the line it would complete for the side to move or for the opponent. It returns a row-major list of the highest-priority candidate points: win, must-block or attack. It sits between the board register and the move-selection (suansha) logic and supports any board size, win length and candidate-list depth.

---
 rtl/threat_scanner_if.sv | 33 +++
 rtl/threat_scanner.sv | 204 ++++++++++++++++++++
 tb/tb_threat_scanner.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/threat_scanner_if.sv
// Request/result bundle between the board owner and the threat scanner.
interface threat_scanner_if #(
    parameter int unsigned BOARD_N  = 15,
    parameter int unsigned MAX_CAND = 10,
    parameter int unsigned COORD_W  = 5,
    parameter int unsigned SIZE_W   = 5
);
    localparam int unsigned BOARD_W = 2 * BOARD_N * BOARD_N;
    localparam int unsigned LIST_W  = MAX_CAND * COORD_W;

    logic               i_start;
    logic               i_turn;
    logic [BOARD_W-1:0] i_board;
    logic [LIST_W-1:0]  o_posX;
    logic [LIST_W-1:0]  o_posY;
    logic [SIZE_W-1:0]  o_size;
    logic [1:0]         o_win;
    logic               o_overflow;
    logic               o_busy;
    logic               o_finish;

    // Requester side: drives the board and start, reads the candidate list.
    modport master (
        output i_start, i_turn, i_board,
        input  o_posX, o_posY, o_size, o_win, o_overflow, o_busy, o_finish
    );

    // Scanner side.
    modport slave (
        input  i_start, i_turn, i_board,
        output o_posX, o_posY, o_size, o_win, o_overflow, o_busy, o_finish
    );
endinterface

// File: rtl/threat_scanner.sv
// Sequential threat scanner: walks a latched board one cell per clock and
// keeps a row-major list of the empty cells with the highest threat level.
module threat_scanner #(
    parameter int unsigned BOARD_N  = 15,
    parameter int unsigned WIN_LEN  = 5,
    parameter int unsigned MAX_CAND = 10,
    parameter int unsigned COORD_W  = 5,
    parameter int unsigned SIZE_W   = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    threat_scanner_if.slave  bus
);
    localparam int unsigned CELLS   = BOARD_N * BOARD_N;
    localparam int unsigned BOARD_W = 2 * CELLS;
    localparam int unsigned BIDX_W  = $clog2(BOARD_W);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [BOARD_W-1:0] r_board;
    logic               r_turn;
    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;
    logic [COORD_W-1:0] r_posx [MAX_CAND];
    logic [COORD_W-1:0] r_posy [MAX_CAND];
    logic [SIZE_W-1:0]  r_size;
    logic [1:0]         r_level;
    logic               r_overflow;
    logic               r_busy;
    logic               r_finish;
    logic               w_last;
    logic [1:0]         w_own;
    logic [1:0]         w_level;

    // Off-board positions read as blocked so runs stop at the edge without wrapping.
    function automatic logic [1:0] cell_at(input int x, input int y);
        logic [BIDX_W-1:0] bi;
        if (x < 0 || y < 0 || x >= int'(BOARD_N) || y >= int'(BOARD_N))
            return 2'b11;
        bi = BIDX_W'(2 * (y * int'(BOARD_N) + x));
        return r_board[bi +: 2];
    endfunction

    // Consecutive side stones from (x,y) along one direction, capped at WIN_LEN-1.
    function automatic int unsigned run_len(input int x, input int y,
                                            input int dx, input int dy,
                                            input logic [1:0] side);
        int unsigned n;
        logic        stop;
        n    = 0;
        stop = 1'b0;
        for (int k = 1; k < int'(WIN_LEN); k++) begin
            if (!stop) begin
                if (cell_at(x + k * dx, y + k * dy) == side) n++;
                else                                         stop = 1'b1;
            end
        end
        return n;
    endfunction

    // Threat level of one cell: 3 own win, 2 must block, 1 own attack, 0 none.
    function automatic logic [1:0] eval_level(input int x, input int y,
                                              input logic [1:0] own);
        logic [1:0]  opp;
        int          dx;
        int          dy;
        int unsigned ro;
        int unsigned rp;
        logic        win_own;
        logic        win_opp;
        logic        atk;
        opp     = ~own;
        win_own = 1'b0;
        win_opp = 1'b0;
        atk     = 1'b0;
        if (cell_at(x, y) != 2'b00) return 2'd0;
        for (int d = 0; d < 4; d++) begin
            dx = (d == 1) ? 0 : 1;
            dy = (d == 0) ? 0 : ((d == 3) ? -1 : 1);
            ro = run_len(x, y, dx, dy, own) + run_len(x, y, -dx, -dy, own);
            rp = run_len(x, y, dx, dy, opp) + run_len(x, y, -dx, -dy, opp);
            if (ro + 1 >= WIN_LEN)     win_own = 1'b1;
            if (rp + 1 >= WIN_LEN)     win_opp = 1'b1;
            if (ro + 1 == WIN_LEN - 1) atk     = 1'b1;
        end
        if (win_own) return 2'd3;
        if (win_opp) return 2'd2;
        if (atk)     return 2'd1;
        return 2'd0;
    endfunction

    // Classify the cell under the scan pointer.
    always_comb begin
        w_own   = r_turn ? 2'b10 : 2'b01;
        w_last  = (r_x == COORD_W'(BOARD_N - 1)) && (r_y == COORD_W'(BOARD_N - 1));
        w_level = eval_level(int'(r_x), int'(r_y), w_own);
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic; a start outside IDLE is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_start) w_state_nxt = S_SCAN;
            S_SCAN:  if (w_last)      w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Board latch, scan pointer, candidate list and status flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_board    <= '0;
            r_turn     <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
            r_size     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            for (int k = 0; k < int'(MAX_CAND); k++) begin
                r_posx[k] <= '0;
                r_posy[k] <= '0;
            end
        end else begin
            r_finish <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_board    <= bus.i_board;
                        r_turn     <= bus.i_turn;
                        r_x        <= '0;
                        r_y        <= '0;
                        r_size     <= '0;
                        r_level    <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        for (int k = 0; k < int'(MAX_CAND); k++) begin
                            r_posx[k] <= '0;
                            r_posy[k] <= '0;
                        end
                    end
                end
                S_SCAN: begin
                    if (r_x == COORD_W'(BOARD_N - 1)) begin
                        r_x <= '0;
                        r_y <= r_y + COORD_W'(1);
                    end else begin
                        r_x <= r_x + COORD_W'(1);
                    end
                    if (w_level > r_level) begin
                        for (int k = 1; k < int'(MAX_CAND); k++) begin
                            r_posx[k] <= '0;
                            r_posy[k] <= '0;
                        end
                        r_posx[0]  <= r_x;
                        r_posy[0]  <= r_y;
                        r_size     <= SIZE_W'(1);
                        r_level    <= w_level;
                        r_overflow <= 1'b0;
                    end else if ((w_level == r_level) && (r_level != 2'd0)) begin
                        if (r_size < SIZE_W'(MAX_CAND)) begin
                            for (int k = 0; k < int'(MAX_CAND); k++) begin
                                if (SIZE_W'(k) == r_size) begin
                                    r_posx[k] <= r_x;
                                    r_posy[k] <= r_y;
                                end
                            end
                            r_size <= r_size + SIZE_W'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                    end
                    if (w_last) r_finish <= 1'b1;
                end
                S_DONE: r_busy <= 1'b0;
                default: r_busy <= 1'b0;
            endcase
        end
    end

    // Pack the candidate slots onto the flat output buses.
    for (genvar g = 0; g < int'(MAX_CAND); g++) begin : g_pack
        assign bus.o_posX[g*COORD_W +: COORD_W] = r_posx[g];
        assign bus.o_posY[g*COORD_W +: COORD_W] = r_posy[g];
    end

    assign bus.o_size     = r_size;
    assign bus.o_win      = r_level;
    assign bus.o_overflow = r_overflow;
    assign bus.o_busy     = r_busy;
    assign bus.o_finish   = r_finish;
endmodule

// File: tb/tb_threat_scanner.sv
// Table-driven bench for threat_scanner with a scoreboard queue of expected lists.
module tb_threat_scanner;
    localparam int unsigned N  = 15;
    localparam int unsigned MC = 10;
    localparam int unsigned CW = 5;
    localparam int unsigned SW = 5;
    localparam int unsigned BW = 2 * N * N;

    typedef struct packed {
        logic [BW-1:0]         board;
        logic                  turn;
        logic [SW-1:0]         size;
        logic [1:0]            win;
        logic                  ovf;
        logic [MC-1:0][CW-1:0] ex;
        logic [MC-1:0][CW-1:0] ey;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    vec_t vecs[5];
    vec_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    threat_scanner_if #(.BOARD_N(N), .MAX_CAND(MC), .COORD_W(CW), .SIZE_W(SW)) bus ();

    threat_scanner #(
        .BOARD_N(N), .WIN_LEN(5), .MAX_CAND(MC), .COORD_W(CW), .SIZE_W(SW)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int x, input int y,
                                          input logic [1:0] v);
        logic [BW-1:0] r;
        r = b;
        r[2*(y*int'(N)+x) +: 2] = v;
        return r;
    endfunction

    function automatic vec_t mk(input logic [BW-1:0] b, input logic t, input int sz,
                                input int w, input logic o);
        vec_t v;
        v       = '0;
        v.board = b;
        v.turn  = t;
        v.size  = SW'(sz);
        v.win   = 2'(w);
        v.ovf   = o;
        return v;
    endfunction

    task automatic check_outputs(input vec_t e, input string tag);
        logic [MC*CW-1:0] px;
        logic [MC*CW-1:0] py;
        px = bus.o_posX;
        py = bus.o_posY;
        chk({tag, " size"}, int'(bus.o_size), int'(e.size));
        chk({tag, " win"}, int'(bus.o_win), int'(e.win));
        chk({tag, " overflow"}, int'(bus.o_overflow), int'(e.ovf));
        for (int k = 0; k < int'(MC); k++) begin
            chk($sformatf("%s x[%0d]", tag, k), int'(px[k*CW +: CW]), int'(e.ex[k]));
            chk($sformatf("%s y[%0d]", tag, k), int'(py[k*CW +: CW]), int'(e.ey[k]));
        end
    endtask

    // Start one scan, optionally re-pulse start mid-scan, then score the result on o_finish.
    task automatic run_case(input vec_t v, input string tag, input int restart_at);
        int   lat;
        vec_t e;
        @(negedge clk);
        bus.i_board = v.board;
        bus.i_turn  = v.turn;
        bus.i_start = 1'b1;
        sb_q.push_back(v);
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_board = '1;
        bus.i_turn  = ~v.turn;
        chk({tag, " busy after start"}, int'(bus.o_busy), 1);
        chk({tag, " size cleared"}, int'(bus.o_size), 0);
        lat = -1;
        for (int c = 1; c <= 400 && lat < 0; c++) begin
            if (c == restart_at) begin
                bus.i_start = 1'b1;
                bus.i_board = vecs[1].board;
            end
            @(negedge clk);
            bus.i_start = 1'b0;
            if (bus.o_finish) lat = c;
        end
        chk({tag, " latency"}, lat, int'(N * N));
        e = sb_q.pop_front();
        if (lat > 0) begin
            chk({tag, " busy in done"}, int'(bus.o_busy), 1);
            check_outputs(e, tag);
            @(negedge clk);
            chk({tag, " finish one cycle"}, int'(bus.o_finish), 0);
            chk({tag, " busy after done"}, int'(bus.o_busy), 0);
            check_outputs(e, {tag, " hold"});
        end
    endtask

    initial begin
        logic [BW-1:0] b;
        int            fin_cnt;
        bus.i_start = 1'b0;
        bus.i_turn  = 1'b0;
        bus.i_board = '0;

        // Vector table.
        vecs[0] = mk('0, 1'b0, 0, 0, 1'b0);
        b = '0;
        for (int x = 3; x <= 6; x++) b = put(b, x, 7, 2'b01);
        vecs[1] = mk(b, 1'b0, 2, 3, 1'b0);
        vecs[1].ex[0] = 5'd2; vecs[1].ey[0] = 5'd7;
        vecs[1].ex[1] = 5'd7; vecs[1].ey[1] = 5'd7;
        vecs[2] = vecs[1];
        vecs[2].turn = 1'b1;
        vecs[2].win  = 2'd2;
        b = '0;
        for (int x = 11; x <= 14; x++) b = put(b, x, 0, 2'b01);
        vecs[3] = mk(b, 1'b0, 1, 3, 1'b0);
        vecs[3].ex[0] = 5'd10; vecs[3].ey[0] = 5'd0;
        b = '0;
        for (int r = 0; r <= 10; r += 2)
            for (int x = 5; x <= 7; x++) b = put(b, x, r, 2'b01);
        vecs[4] = mk(b, 1'b0, 10, 1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            vecs[4].ex[2*k]   = 5'd4; vecs[4].ey[2*k]   = CW'(2*k);
            vecs[4].ex[2*k+1] = 5'd8; vecs[4].ey[2*k+1] = CW'(2*k);
        end

        // Reset state.
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs(vecs[0], "reset");
        chk("reset busy", int'(bus.o_busy), 0);
        chk("reset finish", int'(bus.o_finish), 0);

        // Table: case 0 also re-pulses start mid-scan, which must be ignored.
        for (int i = 0; i < 5; i++)
            run_case(vecs[i], $sformatf("vec%0d", i), (i == 0) ? 50 : 0);

        // Mid-scan reset: ignored restart at 50, reset at 100, no finish afterwards.
        @(negedge clk);
        bus.i_board = vecs[1].board;
        bus.i_turn  = 1'b0;
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int c = 1; c < 100; c++) begin
            if (c == 50) bus.i_start = 1'b1;
            @(negedge clk);
            bus.i_start = 1'b0;
        end
        chk("midscan busy", int'(bus.o_busy), 1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_outputs(vecs[0], "after reset");
        chk("after reset busy", int'(bus.o_busy), 0);
        fin_cnt = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (bus.o_finish) fin_cnt++;
        end
        chk("no finish after reset", fin_cnt, 0);
        run_case(vecs[1], "post reset", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
